spi_audio_tx: RTL and testbench
===============================

# spi_audio_tx

SPI master transmitter that sends 16-bit audio samples off-chip at a fixed frame rate, the transmit-side counterpart of the Pico-to-FPGA SPI audio receive path. Samples from the processing chain are buffered in a small FIFO. One sample is serialized MSB-first per frame tick with active-high CS. When the FIFO runs dry, the last sample is repeated so the downstream converter never starves.

## Interface
- `DATA_W`, 16: sample width in bits.
- `FIFO_DEPTH`, 4: sample FIFO entries; must be a power of 2 and at least 2.
- `SCLK_DIV`, 6: SCLK half-period in `clk_25mhz` cycles. With the default, SCLK is about 2.08 MHz.
- `CS_SETUP`, 2: cycles from CS rise to the first SCLK rise.
- `CS_HOLD`, 2: cycles from the last SCLK fall to CS fall.
- `FRAME_PERIOD`, 521: cycles per frame tick, giving about 48 kHz. Constraint: at least `CS_SETUP + 2*SCLK_DIV*DATA_W + CS_HOLD + 1`.
- `clk_25mhz`  in  1  sole clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `s_data`  in  DATA_W  sample to enqueue.
- `s_valid`  in  1  `s_data` is valid.
- `s_ready`  out  1  FIFO not full.
- `spi_sclk`  out  1  SPI clock; idles low (mode 0).
- `spi_mosi`  out  1  serial data, MSB first.
- `spi_cs`  out  1  chip select, active high.
- `busy`  out  1  high while a frame is in progress (state ≠ IDLE).
- `underrun_cnt`  out  16  present only with the macro in Configuration.

## Operation
- **FIFO push:** a sample is pushed when `s_valid && s_ready`. `s_ready = !full`, derived from the registered occupancy count.
- **Frame counter:** `frame_cnt` counts 0 to FRAME_PERIOD-1 and wraps, free-running from reset release. A tick occurs when `frame_cnt == FRAME_PERIOD-1`.
- **FSM states:** IDLE → SETUP → SHIFT → HOLD → IDLE.
- **IDLE, on tick:**
  - If the FIFO is non-empty, pop the head into the shift register and into `last_sample`.
  - If the FIFO is empty, load `last_sample` and count an underrun.
  - Go to SETUP.
- **SETUP:** `spi_cs` = 1, `spi_mosi` = bit DATA_W-1, `spi_sclk` = 0, held for CS_SETUP cycles.
- **SHIFT:** each bit takes SCLK_DIV cycles low, then SCLK_DIV cycles high.
  - `spi_mosi` advances on the same cycle SCLK falls.
  - The receiver samples on SCLK rise.
  - After the DATA_W-th fall, go to HOLD.
- **HOLD:** `spi_cs` = 1, `spi_sclk` = 0 for CS_HOLD cycles. Then `spi_cs` = 0 and `spi_mosi` = 0, and the FSM returns to IDLE.
- **Tick outside IDLE:** unreachable, since the FRAME_PERIOD constraint forbids it. An assertion checks this under simulation.
- **Simultaneous push and tick with the FIFO empty:** there is no bypass. The tick counts as an underrun and the pushed sample goes out on the next frame.
- **Push while full:** no push occurs (`s_ready` = 0); upstream must hold its data.
- **Push and pop in the same cycle:** occupancy is unchanged and both operations take effect.

## Timing
- **Outputs:** `spi_sclk`, `spi_mosi`, `spi_cs` and `busy` are registered, with no combinational path from the inputs.
- **Reset values:**
  - `spi_cs`, `spi_sclk`, `spi_mosi`, `busy`: 0.
  - `underrun_cnt`, `frame_cnt`, `last_sample`: 0.
  - FIFO: empty, so `s_ready` = 1.
- **Reset mid-frame:** CS drops immediately (asynchronously), the frame is discarded, and the FIFO is flushed.
- **First tick:** FRAME_PERIOD-1 cycles after reset release. The first frame sends 16'h0000 and counts 1 underrun unless a push lands earlier.
- **Frame length:** CS is high for CS_SETUP + 2·SCLK_DIV·DATA_W + CS_HOLD cycles, which is 196 with the defaults.
- **Latency:** from the tick, CS rises on the next cycle and the first SCLK rise comes CS_SETUP + SCLK_DIV cycles after CS rises.

## Configuration
- `SPI_AUDIO_TX_UNDERRUN_CNT_EN` defined:
  - The `underrun_cnt` port exists.
  - It increments on each underrun tick and saturates at 16'hFFFF.
  - It is cleared only by reset.
- Not defined:
  - The port and counter are absent.
  - Repeat-last-sample behaviour is unchanged.

## Structure
- **Package `spi_audio_pkg`:**
  - `SAMPLE_W` = 16.
  - `typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} spi_tx_state_t`.
  - `typedef logic [SAMPLE_W-1:0] sample_t`.
- **Sub-module `spi_audio_tx_fifo`:**
  - Synchronous FIFO, same clock and reset.
  - Ports: push, pop, data in, data out, full, empty.
  - `FIFO_DEPTH`-entry array with wrap-around pointers plus a count.
- **Top level:** holds the frame counter, FSM, SCLK divider, shift register and `last_sample`.

## Test plan
- **Basic frame:**
  - Stimulus: reset, push 16'hC0DE before the first tick.
  - Required: exactly one CS-high window of 196 cycles, and 16 rising SCLK edges sample C,0,D,E MSB-first.
  - Required: `underrun_cnt` = 0.
- **Underrun hold:**
  - Stimulus: push 16'h1234, then no further pushes for three ticks.
  - Required: frames send 1234, 1234, 1234.
  - Required: `underrun_cnt` = 2 with the macro defined.
- **FIFO full:**
  - Stimulus: push 16'h0001 to 16'h0005 back-to-back while idle.
  - Required: `s_ready` drops after 4 accepted pushes and 0005 is held off.
  - Required: after the next tick 0005 is accepted, and the frames send 0001 to 0005 in order.
- **Push/tick collision:**
  - Stimulus: with the FIFO empty, push 16'hA5A5 on the tick cycle.
  - Required: the current frame sends the previous `last_sample`, the next frame sends A5A5, and the underrun count increases by 1.
- **Reset mid-frame:**
  - Stimulus: assert `reset_n` = 0 during the 8th SCLK high phase.
  - Required: same cycle, `spi_cs`, `spi_sclk` and `spi_mosi` = 0.
  - Required: after release, the FIFO is empty and the next frame sends 0000.
- **Saturation (macro defined):**
  - Stimulus: force `underrun_cnt` to 16'hFFFE, then run three empty ticks.
  - Required: the count reads FFFF and stays there.

Source files
------------

// File: rtl/spi_audio_pkg.sv
// Shared types for the SPI audio transmit path.
`timescale 1ns/1ps
package spi_audio_pkg;
  localparam int SAMPLE_W = 16;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} spi_tx_state_t;

  typedef logic [SAMPLE_W-1:0] sample_t;
endpackage

// File: rtl/spi_audio_tx_fifo.sv
// Small synchronous sample FIFO: wrap-around pointers plus an occupancy count.
// Full and empty come straight from the registered count.
`timescale 1ns/1ps
module spi_audio_tx_fifo
  import spi_audio_pkg::*;
#(
  parameter int DATA_W     = SAMPLE_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_25mhz,
  input  logic              reset_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Sample storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk_25mhz) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/spi_audio_tx.sv
// SPI mode-0 audio sample transmitter: one DATA_W-bit sample per frame tick,
// MSB first, active-high CS. An empty FIFO at the tick repeats the last sample.
// Optional underrun counter port enabled by defining SPI_AUDIO_TX_UNDERRUN_CNT_EN.
`timescale 1ns/1ps
module spi_audio_tx
  import spi_audio_pkg::*;
#(
  parameter int DATA_W       = SAMPLE_W,
  parameter int FIFO_DEPTH   = 4,
  parameter int SCLK_DIV     = 6,
  parameter int CS_SETUP     = 2,
  parameter int CS_HOLD      = 2,
  parameter int FRAME_PERIOD = 521
) (
  input  logic              clk_25mhz,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              spi_sclk,
  output logic              spi_mosi,
  output logic              spi_cs,
  output logic              busy
`ifdef SPI_AUDIO_TX_UNDERRUN_CNT_EN
  ,
  output logic [15:0]       underrun_cnt
`endif
);
  localparam int FC_W = $clog2(FRAME_PERIOD);

  logic [FC_W-1:0]   frame_cnt;
  logic              tick;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic [DATA_W-1:0] fifo_rdata;

  spi_tx_state_t     state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [7:0]        bit_q, bit_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] last_q, last_d;
  logic              sclk_q, sclk_d;
  logic              cs_q, cs_d;
  logic              busy_q;

  assign s_ready  = !fifo_full;
  assign tick     = (frame_cnt == FC_W'(FRAME_PERIOD-1));
  assign spi_sclk = sclk_q;
  assign spi_mosi = shreg_q[DATA_W-1];
  assign spi_cs   = cs_q;
  assign busy     = busy_q;

  spi_audio_tx_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_25mhz (clk_25mhz),
    .reset_n   (reset_n),
    .push      (s_valid && !fifo_full),
    .pop       (fifo_pop),
    .wdata     (s_data),
    .rdata     (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Free-running frame counter; the last count value is the frame tick.
  always_ff @(posedge clk_25mhz or negedge reset_n) begin
    if (!reset_n) frame_cnt <= '0;
    else          frame_cnt <= tick ? '0 : frame_cnt + FC_W'(1);
  end

  // Next-state logic: frame sequencing, SCLK phase timing and shift register.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    last_d   = last_q;
    sclk_d   = sclk_q;
    cs_d     = cs_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = SETUP;
          cnt_d   = '0;
          bit_d   = '0;
          cs_d    = 1'b1;
          sclk_d  = 1'b0;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shreg_d  = fifo_rdata;
            last_d   = fifo_rdata;
          end else begin
            shreg_d  = last_q;
          end
        end
      end
      SETUP: begin
        if (cnt_q == 16'(CS_SETUP-1)) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + 16'd1;
        end
      end
      SHIFT: begin
        if (cnt_q == 16'(SCLK_DIV-1)) begin
          sclk_d = 1'b1;
          cnt_d  = cnt_q + 16'd1;
        end else if (cnt_q == 16'(2*SCLK_DIV-1)) begin
          // Falling edge: MOSI moves to the next bit on the same cycle.
          sclk_d  = 1'b0;
          cnt_d   = '0;
          shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
          if (bit_q == 8'(DATA_W-1)) state_d = HOLD;
          else                       bit_d   = bit_q + 8'd1;
        end else begin
          cnt_d  = cnt_q + 16'd1;
        end
      end
      HOLD: begin
        if (cnt_q == 16'(CS_HOLD-1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          cs_d    = 1'b0;
          shreg_d = '0;
        end else begin
          cnt_d   = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset drops CS and discards any frame at once.
  always_ff @(posedge clk_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      last_q  <= '0;
      sclk_q  <= 1'b0;
      cs_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      last_q  <= last_d;
      sclk_q  <= sclk_d;
      cs_q    <= cs_d;
      busy_q  <= (state_d != IDLE);
    end
  end

`ifdef SPI_AUDIO_TX_UNDERRUN_CNT_EN
  logic underrun_evt;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign underrun_evt = (state_q == IDLE) && tick && fifo_empty;

  // Saturating count of ticks that found the FIFO empty.
  always_ff @(posedge clk_25mhz or negedge reset_n) begin
    if (!reset_n)          underrun_cnt <= '0;
    else if (underrun_evt) underrun_cnt <= sat_inc16(underrun_cnt);
  end
`endif

  tick_only_in_idle: assert property (@(posedge clk_25mhz) disable iff (!reset_n)
    tick |-> (state_q == IDLE));
endmodule

// File: tb/tb_spi_audio_tx.sv
// Self-checking bench for spi_audio_tx: a frame-level reference model pushes
// expected samples at each tick; an SPI monitor pops and compares at CS fall.
`timescale 1ns/1ps
module tb_spi_audio_tx;
  localparam int DATA_W       = 16;
  localparam int FIFO_DEPTH   = 4;
  localparam int SCLK_DIV     = 6;
  localparam int CS_SETUP     = 2;
  localparam int CS_HOLD      = 2;
  localparam int FRAME_PERIOD = 521;
  localparam int CS_WIDTH     = 196;

  logic        tb_clk_25mhz = 1'b0;
  logic        reset_n      = 1'b0;
  logic [15:0] s_data       = '0;
  logic        s_valid      = 1'b0;
  logic        s_ready;
  logic        spi_sclk;
  logic        spi_mosi;
  logic        spi_cs;
  logic        busy;
`ifdef SPI_AUDIO_TX_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif

  spi_audio_tx #(
    .DATA_W       (DATA_W),
    .FIFO_DEPTH   (FIFO_DEPTH),
    .SCLK_DIV     (SCLK_DIV),
    .CS_SETUP     (CS_SETUP),
    .CS_HOLD      (CS_HOLD),
    .FRAME_PERIOD (FRAME_PERIOD)
  ) dut (
    .clk_25mhz    (tb_clk_25mhz),
    .reset_n      (reset_n),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .spi_sclk     (spi_sclk),
    .spi_mosi     (spi_mosi),
    .spi_cs       (spi_cs),
    .busy         (busy)
`ifdef SPI_AUDIO_TX_UNDERRUN_CNT_EN
    ,
    .underrun_cnt (underrun_cnt)
`endif
  );

  always #20 tb_clk_25mhz = ~tb_clk_25mhz;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference model of FIFO, last-sample repeat, underrun count and frame ticks.
  logic [15:0] m_fifo[$];
  logic [15:0] exp_q[$];
  logic [15:0] m_last  = '0;
  logic [15:0] m_under = '0;
  int          m_fc    = 0;
  bit          m_rdy;

  always @(posedge tb_clk_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      m_fifo.delete();
      exp_q.delete();
      m_last  = '0;
      m_under = '0;
      m_fc    = 0;
    end else begin
      m_rdy = (m_fifo.size() < FIFO_DEPTH);
      if (m_fc == FRAME_PERIOD-1) begin
        if (m_fifo.size() > 0)        m_last = m_fifo.pop_front();
        else if (m_under != 16'hFFFF) m_under = m_under + 16'd1;
        exp_q.push_back(m_last);
        m_fc = 0;
      end else begin
        m_fc++;
      end
      if (s_valid && m_rdy) m_fifo.push_back(s_data);
    end
  end

  // SPI receiver: samples MOSI on SCLK rise, checks each completed frame.
  logic        prev_cs   = 1'b0;
  logic        prev_sclk = 1'b0;
  logic [15:0] rx        = '0;
  int          rises     = 0;
  int          width     = 0;
  int          frames_done = 0;
  logic [15:0] exp_word;

  always @(negedge tb_clk_25mhz) begin
    if (!reset_n) begin
      prev_cs = 1'b0; prev_sclk = 1'b0; rises = 0; width = 0; rx = '0;
    end else begin
      if (spi_cs && !prev_cs) chk("busy_at_cs_rise", busy, 1);
      if (spi_cs) width++;
      if (spi_sclk && !prev_sclk) begin
        chk("cs_during_sclk", spi_cs, 1);
        rx = {rx[14:0], spi_mosi};
        rises++;
      end
      if (!spi_cs && prev_cs) begin
        chk("cs_width", width, CS_WIDTH);
        chk("sclk_rises", rises, DATA_W);
        chk("exp_available", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          exp_word = exp_q.pop_front();
          chk("frame_data", rx, exp_word);
        end
        frames_done++;
        width = 0;
        rises = 0;
      end
      prev_cs   = spi_cs;
      prev_sclk = spi_sclk;
    end
  end

  task automatic wait_frames(input int n);
    int target;
    int cyc;
    target = frames_done + n;
    cyc    = 0;
    while (frames_done < target && cyc < (n + 2) * FRAME_PERIOD) begin
      @(negedge tb_clk_25mhz);
      cyc++;
    end
    chk("frame_wait", frames_done >= target, 1);
  endtask

  // Called at a negedge; holds s_valid until a push is accepted.
  task automatic push_word(input logic [15:0] d);
    logic acc;
    int   cyc;
    acc = 1'b0;
    cyc = 0;
    s_valid = 1'b1;
    s_data  = d;
    while (!acc && cyc < 2 * FRAME_PERIOD) begin
      acc = s_ready;
      @(negedge tb_clk_25mhz);
      cyc++;
    end
    s_valid = 1'b0;
    chk("push_accepted", acc, 1);
  endtask

  logic [15:0] under0;

  initial begin
    // Reset state
    repeat (3) @(negedge tb_clk_25mhz);
    chk("rst_cs", spi_cs, 0);
    chk("rst_sclk", spi_sclk, 0);
    chk("rst_mosi", spi_mosi, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", s_ready, 1);
`ifdef SPI_AUDIO_TX_UNDERRUN_CNT_EN
    chk("rst_underrun", underrun_cnt, 0);
`endif
    reset_n = 1'b1;

    // Basic frame
    @(negedge tb_clk_25mhz);
    push_word(16'hC0DE);
    wait_frames(1);
`ifdef SPI_AUDIO_TX_UNDERRUN_CNT_EN
    chk("underrun_basic", underrun_cnt, 0);
`endif

    // Underrun hold: one sample, three frames
    push_word(16'h1234);
    wait_frames(3);
`ifdef SPI_AUDIO_TX_UNDERRUN_CNT_EN
    chk("underrun_hold", underrun_cnt, 2);
`endif

    // FIFO full: four accepted, fifth held until a tick pops
    for (int i = 1; i <= 4; i++) push_word(16'(i));
    chk("full_ready_low", s_ready, 0);
    push_word(16'h0005);
    wait_frames(5);
`ifdef SPI_AUDIO_TX_UNDERRUN_CNT_EN
    chk("underrun_full", underrun_cnt, m_under);
`endif

    // Push exactly on the tick cycle with the FIFO empty
    begin
      int cyc;
      cyc = 0;
      while (m_fc != FRAME_PERIOD-1 && cyc < 2 * FRAME_PERIOD) begin
        @(negedge tb_clk_25mhz);
        cyc++;
      end
      chk("collision_align", m_fc, FRAME_PERIOD-1);
    end
`ifdef SPI_AUDIO_TX_UNDERRUN_CNT_EN
    under0 = underrun_cnt;
`else
    under0 = m_under;
`endif
    chk("collision_ready", s_ready, 1);
    s_valid = 1'b1;
    s_data  = 16'hA5A5;
    @(negedge tb_clk_25mhz);
    s_valid = 1'b0;
    wait_frames(2);
`ifdef SPI_AUDIO_TX_UNDERRUN_CNT_EN
    chk("underrun_collision", underrun_cnt, under0 + 16'd1);
`endif

    // Reset during the 8th SCLK high phase, with a sample still queued
    push_word(16'hBEEF);
    push_word(16'h1111);
    begin
      int cyc;
      cyc = 0;
      while (!(rises >= 8 && spi_sclk && spi_cs) && cyc < 2 * FRAME_PERIOD) begin
        @(negedge tb_clk_25mhz);
        cyc++;
      end
      chk("reach_8th_high", rises >= 8 && spi_sclk, 1);
    end
    reset_n = 1'b0;
    #1;
    chk("midrst_cs", spi_cs, 0);
    chk("midrst_sclk", spi_sclk, 0);
    chk("midrst_mosi", spi_mosi, 0);
    repeat (2) @(negedge tb_clk_25mhz);
    reset_n = 1'b1;
    @(negedge tb_clk_25mhz);
    chk("midrst_ready", s_ready, 1);
    chk("midrst_busy", busy, 0);
    wait_frames(1);
`ifdef SPI_AUDIO_TX_UNDERRUN_CNT_EN
    chk("underrun_after_rst", underrun_cnt, 1);

    // Saturation
    force dut.underrun_cnt = 16'hFFFE;
    m_under = 16'hFFFE;
    @(negedge tb_clk_25mhz);
    release dut.underrun_cnt;
    @(negedge tb_clk_25mhz);
    chk("sat_start", underrun_cnt, 16'hFFFE);
    for (int i = 0; i < 3; i++) begin
      wait_frames(1);
      chk("sat_track", underrun_cnt, m_under);
    end
    chk("sat_final", underrun_cnt, 16'hFFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
